voice_read_requester: RTL and testbench
=======================================

Name: voice_read_requester

Overview:
- Upstream feeder of the DRAM traffic arbiter's audio read-address AXIS FIFO; runs on the DRAM controller clock.
- Holds per-voice playback pointers for NUM_VOICES sample voices. On each audio sample tick it emits one 40-bit read request per active voice: the 128-bit line address plus a sample-period tag.
- Downstream audio logic uses the tag to regroup the returned lines by sample period.

Parameters:
- NUM_VOICES, 8: number of voices; must be a power of 2, at least 2.
- ADDR_W, 24: DRAM line address width (one line = 128 bits = 8 16-bit samples).
- PERIOD_W, 14: sample-period tag width.

Ports:
- clk_dram_ctrl, in, 1: clock.
- rst_dram_ctrl_n, in, 1: asynchronous active-low reset.
- sample_load_complete, in, 1: DRAM sample image loaded; no requests are issued while low.
- sample_tick, in, 1: one-cycle pulse per audio sample period.
- trig_valid, in, 1: start (or restart) a voice.
- trig_voice, in, $clog2(NUM_VOICES): voice index.
- trig_start_sample, in, ADDR_W+3: first sample index (line = [ADDR_W+2:3], lane = [2:0]).
- trig_length, in, ADDR_W+3: number of samples to play; 0 means ignore the trigger.
- read_addr_axis_data, out, 40: {2'b0, period[13:0], line_addr[23:0]}.
- read_addr_axis_valid, out, 1: request valid.
- read_addr_axis_tlast, out, 1: last request of the current tick.
- read_addr_axis_ready, in, 1: downstream ready.
- voice_active, out, NUM_VOICES: per-voice playing flag.
- tick_overrun, out, 1: sticky flag, set when a tick is dropped.

Behaviour:
- Reset values: all outputs 0; all voice pointers, remaining counts and period counter 0; FSM in IDLE.
- Per-voice state: ptr (ADDR_W+3 bits), remaining (ADDR_W+3 bits), active.
- Period counter: PERIOD_W bits, +1 on every accepted tick, wraps 2^14-1 -> 0.
- Period counter: does not advance on dropped ticks.
- FSM states: IDLE, SCAN, HOLD.
- IDLE: a sample_tick with sample_load_complete=1 and any voice active:
  - latches the tick's period value;
  - sets scan index to 0;
  - moves to SCAN.
- IDLE: a tick with no active voice increments the period counter only.
- SCAN: each cycle inspects voice[idx].
  - Inactive voice: idx+1, costs 1 cycle.
  - Active voice: load the output register with {2'b0, period, ptr[ADDR_W+2:3]}, assert valid, move to HOLD.
  - tlast=1 when no active voice exists at a higher index.
  - idx wrapping past NUM_VOICES-1 returns the FSM to IDLE.
- HOLD: data, valid and tlast are held stable until ready.
- On handshake in HOLD:
  - ptr+1 and remaining-1 for that voice;
  - remaining reaching 0 clears active;
  - continue SCAN at idx+1, or go to IDLE if tlast was set.
- Throughput: worst case NUM_VOICES*2 cycles per tick with ready tied high. Output data is registered; no combinational path from ready to data.
- Ticks while not in IDLE: the tick is dropped, the period counter is not advanced, tick_overrun is set (sticky until reset).
- Triggers are accepted in any state, take 1 cycle, and set ptr=start, remaining=length, active=1.
- A trigger and a handshake to the same voice in the same cycle: the trigger wins, and the advance is discarded.
- Output register contents are not altered by triggers.
- Trigger to a voice already scanned this tick: no request for it until the next tick.
- Trigger with length 0: no state change.
- sample_load_complete low: ticks are ignored entirely (no count, no overrun); triggers are still accepted.
- Pointer wrap at 2^(ADDR_W+3) wraps naturally; no error is flagged.
- Asynchronous reset mid-HOLD: valid drops immediately and all state clears.

Decomposition:
- Package audio_req_pkg:
  - typedef read_req_t: packed 40-bit struct {pad[1:0], period[13:0], addr[23:0]};
  - constants SAMPLES_PER_LINE = 8 and LANE_W = 3;
  - FSM enum.
- The arbiter's read-address field slicing must come from the same package.
- One natural sub-module, voice_state_bank: holds the voice registers and applies the trigger/advance priority. It exposes active, ptr and a next-active-above-index lookup.

Test Plan:
- Reset with sample_load_complete=1; trigger voice 2 with start=0x000010, length=3; pulse 4 ticks, ready=1.
  - Required: requests with addr=0x000002 at periods 0, 1, 2, each with tlast=1; voice_active[2] falls after the third request; tick 4 produces no request and the period counter goes to 4.
- Voices 0 and 5 active, ready held low for 10 cycles after valid.
  - Required: data stable for all 10 cycles; after release, voice 0 request (tlast=0) then voice 5 request (tlast=1), same period tag.
- 8 active voices, ready low for 20 cycles, second tick during HOLD.
  - Required: tick_overrun=1; only 8 requests emitted; the next accepted tick carries a period tag exactly 1 greater.
- Retrigger voice 3 (start=0x80, length=16) in the same cycle as its handshake.
  - Required: the next tick requests addr=0x000010, and the remaining count is 16.
- sample_load_complete=0 with 5 ticks and 1 trigger.
  - Required: no valid, no overrun, and the first tick after load-complete carries period 0.
- Assert rst_dram_ctrl_n low asynchronously mid-HOLD.
  - Required: valid, voice_active and tick_overrun all read 0 before the next clock edge.

Source files
------------

// File: rtl/audio_req_pkg.sv
// audio_req_pkg: shared read-request format, line/lane geometry and requester FSM states
package audio_req_pkg;
    localparam int SAMPLES_PER_LINE = 8;
    localparam int LANE_W = $clog2(SAMPLES_PER_LINE);
    localparam int REQ_PERIOD_W = 14;
    localparam int REQ_ADDR_W = 24;

    typedef struct packed {
        logic [1:0]              pad;
        logic [REQ_PERIOD_W-1:0] period;
        logic [REQ_ADDR_W-1:0]   addr;
    } read_req_t;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} req_state_t;

    function automatic read_req_t make_req(input logic [REQ_PERIOD_W-1:0] period,
                                           input logic [REQ_ADDR_W-1:0] addr);
        make_req = '{pad: 2'b00, period: period, addr: addr};
    endfunction
endpackage

// File: rtl/voice_read_requester_if.sv
// voice_read_requester_if: AXIS read-address channel toward the arbiter's audio FIFO
interface voice_read_requester_if;
    import audio_req_pkg::*;
    read_req_t data;
    logic      valid;
    logic      tlast;
    logic      ready;
    modport master(output data, valid, tlast, input ready);
    modport slave(input data, valid, tlast, output ready);
endinterface

// File: rtl/voice_read_requester_bank.sv
// voice_state_bank: per-voice pointer/remaining/active registers with trigger-over-advance priority
module voice_state_bank
    import audio_req_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int ADDR_W = 24,
    localparam int VI_W = $clog2(NUM_VOICES),
    localparam int PTR_W = ADDR_W + LANE_W
) (
    input  logic                  clk_dram_ctrl,
    input  logic                  rst_dram_ctrl_n,
    input  logic                  trig_valid,
    input  logic [VI_W-1:0]       trig_voice,
    input  logic [PTR_W-1:0]      trig_start_sample,
    input  logic [PTR_W-1:0]      trig_length,
    input  logic                  adv_valid,
    input  logic [VI_W-1:0]       adv_voice,
    input  logic [VI_W-1:0]       sel_idx,
    output logic [PTR_W-1:0]      sel_ptr,
    output logic                  more_above,
    output logic [NUM_VOICES-1:0] active
);
    logic [PTR_W-1:0] ptr [NUM_VOICES];
    logic [PTR_W-1:0] remaining [NUM_VOICES];

    assign sel_ptr = ptr[sel_idx];

    // A trigger overrides a same-cycle advance on the same voice; zero-length triggers are ignored
    always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
        if (!rst_dram_ctrl_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                ptr[v] <= '0;
                remaining[v] <= '0;
            end
            active <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (trig_valid && trig_length != '0 && trig_voice == VI_W'(v)) begin
                    ptr[v] <= trig_start_sample;
                    remaining[v] <= trig_length;
                    active[v] <= 1'b1;
                end else if (adv_valid && adv_voice == VI_W'(v)) begin
                    ptr[v] <= ptr[v] + 1'b1;
                    remaining[v] <= remaining[v] - 1'b1;
                    if (remaining[v] == PTR_W'(1)) active[v] <= 1'b0;
                end
            end
        end
    end

    // Any active voice strictly above the scan index means this request is not the tick's last
    always_comb begin
        more_above = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++)
            if (VI_W'(v) > sel_idx && active[v]) more_above = 1'b1;
    end
endmodule

// File: rtl/voice_read_requester.sv
// voice_read_requester: per-tick scan of active voices issuing tagged DRAM line read requests
module voice_read_requester
    import audio_req_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int ADDR_W = 24,
    parameter int PERIOD_W = 14,
    localparam int VI_W = $clog2(NUM_VOICES),
    localparam int PTR_W = ADDR_W + LANE_W
) (
    input  logic                   clk_dram_ctrl,
    input  logic                   rst_dram_ctrl_n,
    input  logic                   sample_load_complete,
    input  logic                   sample_tick,
    input  logic                   trig_valid,
    input  logic [VI_W-1:0]        trig_voice,
    input  logic [PTR_W-1:0]       trig_start_sample,
    input  logic [PTR_W-1:0]       trig_length,
    voice_read_requester_if.master read_addr_axis,
    output logic [NUM_VOICES-1:0]  voice_active,
    output logic                   tick_overrun
);
    req_state_t          state, state_nxt;
    logic [VI_W-1:0]     idx, idx_nxt;
    logic [PERIOD_W-1:0] period_cnt, tick_period;
    read_req_t           req_q;
    logic                valid_q, tlast_q, load, adv, more_above, tick_ok;
    logic [PTR_W-1:0]    sel_ptr;

    assign tick_ok = sample_tick && sample_load_complete;
    assign read_addr_axis.data = req_q;
    assign read_addr_axis.valid = valid_q;
    assign read_addr_axis.tlast = tlast_q;

    voice_state_bank #(.NUM_VOICES(NUM_VOICES), .ADDR_W(ADDR_W)) u_bank (
        .clk_dram_ctrl(clk_dram_ctrl),
        .rst_dram_ctrl_n(rst_dram_ctrl_n),
        .trig_valid(trig_valid),
        .trig_voice(trig_voice),
        .trig_start_sample(trig_start_sample),
        .trig_length(trig_length),
        .adv_valid(adv),
        .adv_voice(idx),
        .sel_idx(idx),
        .sel_ptr(sel_ptr),
        .more_above(more_above),
        .active(voice_active)
    );

    // Scan sequencing: skip idle voices, park in HOLD on a request until the consumer takes it
    always_comb begin
        state_nxt = state;
        idx_nxt = idx;
        load = 1'b0;
        adv = 1'b0;
        case (state)
            IDLE: if (tick_ok && |voice_active) begin
                state_nxt = SCAN;
                idx_nxt = '0;
            end
            SCAN: if (voice_active[idx]) begin
                load = 1'b1;
                state_nxt = HOLD;
            end else begin
                idx_nxt = idx + 1'b1;
                if (idx == VI_W'(NUM_VOICES - 1)) state_nxt = IDLE;
            end
            HOLD: if (read_addr_axis.ready) begin
                adv = 1'b1;
                idx_nxt = idx + 1'b1;
                state_nxt = tlast_q ? IDLE : SCAN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, period bookkeeping, overrun flag and the registered output request
    always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
        if (!rst_dram_ctrl_n) begin
            state <= IDLE;
            idx <= '0;
            period_cnt <= '0;
            tick_period <= '0;
            req_q <= '0;
            valid_q <= 1'b0;
            tlast_q <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
            if (tick_ok && state == IDLE) begin
                period_cnt <= period_cnt + 1'b1;
                tick_period <= period_cnt;
            end
            if (tick_ok && state != IDLE) tick_overrun <= 1'b1;
            if (load) begin
                req_q <= make_req(REQ_PERIOD_W'(tick_period), REQ_ADDR_W'(sel_ptr[PTR_W-1:LANE_W]));
                tlast_q <= !more_above;
            end
            valid_q <= load | (valid_q & ~adv);
        end
    end
endmodule

// File: tb/tb_voice_read_requester.sv
// tb_voice_read_requester: randomized and directed checks against a transaction-level voice model
module tb_voice_read_requester;
    import audio_req_pkg::*;
    localparam int NV = 8;
    localparam int LW = 27;
    localparam int PMASK = (1 << LW) - 1;

    logic clk_dram_ctrl = 1'b0;
    logic rst_dram_ctrl_n = 1'b0;
    logic sample_load_complete = 1'b0;
    logic sample_tick = 1'b0;
    logic trig_valid = 1'b0;
    logic [2:0] trig_voice = '0;
    logic [LW-1:0] trig_start_sample = '0;
    logic [LW-1:0] trig_length = '0;
    logic [NV-1:0] voice_active;
    logic tick_overrun;

    voice_read_requester_if read_addr_axis();

    voice_read_requester #(.NUM_VOICES(NV), .ADDR_W(24), .PERIOD_W(14)) dut (
        .clk_dram_ctrl(clk_dram_ctrl),
        .rst_dram_ctrl_n(rst_dram_ctrl_n),
        .sample_load_complete(sample_load_complete),
        .sample_tick(sample_tick),
        .trig_valid(trig_valid),
        .trig_voice(trig_voice),
        .trig_start_sample(trig_start_sample),
        .trig_length(trig_length),
        .read_addr_axis(read_addr_axis),
        .voice_active(voice_active),
        .tick_overrun(tick_overrun)
    );

    always #5 clk_dram_ctrl = ~clk_dram_ctrl;

    typedef struct {
        logic [39:0] data;
        logic        tlast;
        int          voice;
    } exp_t;

    exp_t q[$];
    int m_ptr[NV];
    int m_rem[NV];
    bit m_act[NV];
    int m_cnt;
    bit m_ovr;
    bit hs;
    int n_cmp = 0;
    int n_bad = 0;
    logic [39:0] seen_data[$];
    logic seen_last[$];

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_ptr[v] = 0;
            m_rem[v] = 0;
            m_act[v] = 0;
        end
        q.delete();
        m_cnt = 0;
        m_ovr = 0;
        hs = 0;
    endfunction

    function automatic logic [NV-1:0] model_active();
        logic [NV-1:0] a = '0;
        for (int v = 0; v < NV; v++) a[v] = m_act[v];
        return a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: consume accepted requests, act on ticks, then apply triggers
    always @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
        int v, last;
        bit busy;
        if (!rst_dram_ctrl_n) model_reset();
        else begin
            busy = q.size() != 0;
            if (hs) begin
                v = q[0].voice;
                void'(q.pop_front());
                m_ptr[v] = (m_ptr[v] + 1) & PMASK;
                m_rem[v] = m_rem[v] - 1;
                if (m_rem[v] == 0) m_act[v] = 0;
                hs = 0;
            end
            if (sample_tick && sample_load_complete) begin
                if (busy) m_ovr = 1;
                else begin
                    last = -1;
                    for (int i = 0; i < NV; i++) if (m_act[i]) last = i;
                    for (int i = 0; i < NV; i++)
                        if (m_act[i])
                            q.push_back('{data: {2'b00, 14'(m_cnt), 24'(m_ptr[i] / 8)},
                                          tlast: (i == last), voice: i});
                    m_cnt = (m_cnt + 1) % 16384;
                end
            end
            if (trig_valid && trig_length != 0) begin
                m_ptr[trig_voice] = int'(trig_start_sample);
                m_rem[trig_voice] = int'(trig_length);
                m_act[trig_voice] = 1;
            end
        end
    end

    // Compare every cycle away from the active edge; note handshakes for the model
    always @(negedge clk_dram_ctrl) begin
        if (rst_dram_ctrl_n) begin
            check("voice_active", voice_active, model_active());
            check("tick_overrun", tick_overrun, m_ovr);
            if (read_addr_axis.valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid actual=%h required=no_request t=%0t", read_addr_axis.data, $time);
                end else begin
                    check("req_data", read_addr_axis.data, q[0].data);
                    check("req_tlast", read_addr_axis.tlast, q[0].tlast);
                end
                if (read_addr_axis.ready) begin
                    hs = 1;
                    seen_data.push_back(read_addr_axis.data);
                    seen_last.push_back(read_addr_axis.tlast);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_dram_ctrl);
        #1;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic trig(input int v, input int s, input int l);
        trig_valid = 1'b1;
        trig_voice = 3'(v);
        trig_start_sample = LW'(s);
        trig_length = LW'(l);
        step();
        trig_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("idle_pending", 64'(q.size()), 64'd0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!read_addr_axis.valid && n < budget) begin
            step();
            n++;
        end
        check("valid_timeout", read_addr_axis.valid, 1'b1);
    endtask

    task automatic do_reset(input logic load);
        rst_dram_ctrl_n = 1'b0;
        sample_load_complete = load;
        read_addr_axis.ready = 1'b1;
        step();
        step();
        rst_dram_ctrl_n = 1'b1;
        step();
        seen_data.delete();
        seen_last.delete();
    endtask

    initial begin
        logic [39:0] sd;
        read_addr_axis.ready = 1'b1;
        model_reset();
        do_reset(1'b1);
        check("reset_valid", read_addr_axis.valid, 1'b0);
        check("reset_active", voice_active, '0);

        // single voice, three samples in one line
        trig(2, 'h10, 3);
        for (int t = 0; t < 4; t++) begin
            tick();
            wait_idle(40);
        end
        step();
        check("t1_count", 64'(seen_data.size()), 64'd3);
        for (int i = 0; i < 3 && i < seen_data.size(); i++) begin
            check("t1_data", seen_data[i], 40'h0000000002 | (40'(i) << 24));
            check("t1_tlast", seen_last[i], 1'b1);
        end
        check("t1_active2", voice_active[2], 1'b0);
        check("t1_period_cnt", 64'(m_cnt), 64'd4);

        // back-pressure with two voices
        do_reset(1'b1);
        trig(0, 'h100, 2);
        trig(5, 'h208, 2);
        read_addr_axis.ready = 1'b0;
        tick();
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_data", read_addr_axis.data, 40'h0000000020);
            check("t2_hold_valid", read_addr_axis.valid, 1'b1);
            step();
        end
        read_addr_axis.ready = 1'b1;
        wait_idle(40);
        check("t2_count", 64'(seen_data.size()), 64'd2);
        if (seen_data.size() == 2) begin
            check("t2_v0", seen_data[0], 40'h0000000020);
            check("t2_v0_last", seen_last[0], 1'b0);
            check("t2_v5", seen_data[1], 40'h0000000041);
            check("t2_v5_last", seen_last[1], 1'b1);
        end

        // all voices, a dropped tick during HOLD
        do_reset(1'b1);
        for (int v = 0; v < NV; v++) trig(v, v * 128, 4);
        read_addr_axis.ready = 1'b0;
        tick();
        step();
        step();
        tick();
        for (int i = 0; i < 20; i++) step();
        check("t3_overrun", tick_overrun, 1'b1);
        read_addr_axis.ready = 1'b1;
        wait_idle(60);
        check("t3_count", 64'(seen_data.size()), 64'd8);
        seen_data.delete();
        tick();
        wait_idle(60);
        if (seen_data.size() > 0) begin
            sd = seen_data[0];
            check("t3_next_period", sd[37:24], 14'd1);
        end else check("t3_next_present", 64'd0, 64'd1);

        // retrigger in the handshake cycle
        do_reset(1'b1);
        trig(3, 'h400, 2);
        read_addr_axis.ready = 1'b0;
        tick();
        wait_valid(20);
        read_addr_axis.ready = 1'b1;
        trig(3, 'h80, 16);
        check("t4_model_rem", 64'(m_rem[3]), 64'd16);
        check("t4_active3", voice_active[3], 1'b1);
        wait_idle(40);
        seen_data.delete();
        for (int t = 0; t < 16; t++) begin
            tick();
            wait_idle(40);
        end
        step();
        check("t4_count", 64'(seen_data.size()), 64'd16);
        if (seen_data.size() > 0) check("t4_first", seen_data[0], 40'h0001000010);
        check("t4_done", voice_active[3], 1'b0);

        // sample image not loaded
        do_reset(1'b0);
        tick();
        tick();
        trig(1, 'h18, 2);
        tick();
        step();
        tick();
        tick();
        step();
        check("t5_overrun", tick_overrun, 1'b0);
        check("t5_count", 64'(seen_data.size()), 64'd0);
        sample_load_complete = 1'b1;
        step();
        tick();
        wait_idle(40);
        if (seen_data.size() > 0) check("t5_first", seen_data[0], 40'h0000000003);
        else check("t5_first_present", 64'd0, 64'd1);

        // asynchronous reset while holding a request
        do_reset(1'b1);
        trig(4, 'h50, 5);
        read_addr_axis.ready = 1'b0;
        tick();
        wait_valid(20);
        tick();
        step();
        @(negedge clk_dram_ctrl);
        #2;
        rst_dram_ctrl_n = 1'b0;
        #1;
        check("t6_valid", read_addr_axis.valid, 1'b0);
        check("t6_active", voice_active, '0);
        check("t6_overrun", tick_overrun, 1'b0);
        step();
        rst_dram_ctrl_n = 1'b1;
        read_addr_axis.ready = 1'b1;
        step();

        // randomized traffic
        do_reset(1'b1);
        for (int c = 0; c < 1500; c++) begin
            read_addr_axis.ready = ($urandom_range(0, 3) != 0);
            if (q.size() == 0 && $urandom_range(0, 5) == 0) begin
                trig_valid = 1'b1;
                trig_voice = 3'($urandom_range(0, NV - 1));
                trig_start_sample = ($urandom_range(0, 3) == 0) ? LW'(PMASK - $urandom_range(0, 15)) : LW'($urandom);
                trig_length = LW'($urandom_range(0, 5));
            end else begin
                trig_valid = 1'b0;
                sample_tick = ($urandom_range(0, 7) == 0);
            end
            step();
            trig_valid = 1'b0;
            sample_tick = 1'b0;
        end
        read_addr_axis.ready = 1'b1;
        wait_idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
